// File: rtl/imem_boot_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
interface imem_boot_loader_if #(
    parameter int unsigned ADDR_W = 10
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [ADDR_W-1:0] mem_a;
    logic [31:0]       mem_d;
    logic              mem_we;

    // Environment side: byte source and memory write port
    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  mem_a,
        input  mem_d,
        input  mem_we
    );

    // Loader side
    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output mem_a,
        output mem_d,
        output mem_we
    );
endinterface

// File: rtl/imem_boot_loader.sv
// Boot loader: packs a big-endian byte stream into 32-bit words, writes them
// to consecutive instruction-memory addresses and holds the CPU until the
// FINISH word has been written.
module imem_boot_loader #(
    parameter int unsigned DEPTH    = 1024,
    parameter int unsigned ADDR_W   = 10,
    parameter logic [31:0] END_WORD = 32'hFC000000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    imem_boot_loader_if.slave   bus,
    output logic                cpu_run,
    output logic                load_done,
    output logic                load_err,
    output logic [ADDR_W:0]     word_count
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [ADDR_W:0] LAST_COUNT = CNT_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        WRITE,
        DONE,
        ERROR
    } state_t;

    state_t      state;
    logic [1:0]  byte_cnt;
    logic [23:0] word_q;    // first three bytes of the word in flight

    // Load sequencer; every output is a register updated here
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            byte_cnt     <= '0;
            word_q       <= '0;
            bus.rx_ready <= 1'b0;
            bus.mem_a    <= '0;
            bus.mem_d    <= '0;
            bus.mem_we   <= 1'b0;
            cpu_run      <= 1'b0;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
            word_count   <= '0;
        end else begin
            case (state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        state        <= RECV;
                        bus.rx_ready <= 1'b1;
                        cpu_run      <= 1'b0;
                        load_done    <= 1'b0;
                        load_err     <= 1'b0;
                        word_count   <= '0;
                        byte_cnt     <= '0;
                        word_q       <= '0;
                    end
                end

                RECV: begin
                    if (bus.rx_valid && bus.rx_ready) begin
                        if (byte_cnt == 2'd3) begin
                            state        <= WRITE;
                            bus.rx_ready <= 1'b0;
                            bus.mem_we   <= 1'b1;
                            bus.mem_a    <= word_count[ADDR_W-1:0];
                            bus.mem_d    <= {word_q, bus.rx_data};
                            byte_cnt     <= '0;
                        end else begin
                            word_q   <= {word_q[15:0], bus.rx_data};
                            byte_cnt <= byte_cnt + 2'd1;
                        end
                    end
                end

                WRITE: begin
                    bus.mem_we <= 1'b0;
                    word_count <= word_count + CNT_W'(1);
                    // FINISH wins even when it lands on the last address
                    if (bus.mem_d == END_WORD) begin
                        state     <= DONE;
                        load_done <= 1'b1;
                        cpu_run   <= 1'b1;
                    end else if (word_count == LAST_COUNT) begin
                        state    <= ERROR;
                        load_err <= 1'b1;
                    end else begin
                        state        <= RECV;
                        bus.rx_ready <= 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: a cycle table for the basic load plus
// hand-written sequences for throttling, overflow, last-address FINISH and
// reset/reload.
module tb_imem_boot_loader;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DEPTH  = 1024;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              cpu_run;
    logic              load_done;
    logic              load_err;
    logic [ADDR_W:0]   word_count;

    imem_boot_loader_if #(.ADDR_W(ADDR_W)) bif ();

    imem_boot_loader #(
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .END_WORD (32'hFC000000)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .bus        (bif),
        .cpu_run    (cpu_run),
        .load_done  (load_done),
        .load_err   (load_err),
        .word_count (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Memory model and write log
    logic [31:0]       mem_model [DEPTH];
    int                wr_cnt = 0;
    int                dbl    = 0;
    logic              last_we = 1'b0;
    logic [ADDR_W-1:0] first_a, last_a;
    logic [31:0]       first_d, last_d;

    always @(posedge clk) begin
        if (bif.mem_we === 1'b1) begin
            mem_model[bif.mem_a] = bif.mem_d;
            if (wr_cnt == 0) begin
                first_a = bif.mem_a;
                first_d = bif.mem_d;
            end
            last_a = bif.mem_a;
            last_d = bif.mem_d;
            wr_cnt = wr_cnt + 1;
            if (last_we) dbl = dbl + 1;
        end
        last_we = (bif.mem_we === 1'b1);
    end

    typedef struct {
        bit          start;
        bit          valid;
        logic [7:0]  data;
        logic [57:0] exp;
    } vec_t;

    vec_t vecs [18];

    function automatic vec_t mk(bit s, bit v, logic [7:0] d, bit r, bit we, int a,
                                logic [31:0] md, int wc, bit run, bit done, bit err);
        vec_t t;
        t.start = s;
        t.valid = v;
        t.data  = d;
        t.exp   = {r, we, 10'(a), md, 11'(wc), run, done, err};
        return t;
    endfunction

    function automatic logic [57:0] outs();
        return {bif.rx_ready, bif.mem_we, bif.mem_a, bif.mem_d, word_count,
                cpu_run, load_done, load_err};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Called just after a negedge; returns just after the negedge following acceptance
    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) begin
            bif.rx_valid = 1'b0;
            @(negedge clk);
        end
        bif.rx_valid = 1'b1;
        bif.rx_data  = b;
        for (int t = 0; t < 200; t++) begin
            if (bif.rx_ready === 1'b1) begin
                @(negedge clk);
                bif.rx_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        bif.rx_valid = 1'b0;
        chk("byte_accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_word(input logic [31:0] w, input int max_gap);
        logic [31:0] tmp;
        tmp = w;
        for (int i = 0; i < 4; i++) begin
            send_byte(tmp[31:24], (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap)));
            tmp = {tmp[23:0], 8'h00};
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input string name);
        for (int t = 0; t < 50; t++) begin
            if (load_done === 1'b1 || load_err === 1'b1) return;
            @(negedge clk);
        end
        chk({name, "_end_timeout"}, 64'd0, 64'd1);
    endtask

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        bif.rx_valid = 1'b0;
        bif.rx_data  = 8'h00;

        // Basic load, one row per cycle: inputs for the cycle, outputs seen in it
        vecs[0]  = mk(1, 0, 8'h00, 0, 0, 0, 32'h0,        0, 0, 0, 0);
        vecs[1]  = mk(0, 1, 8'h20, 1, 0, 0, 32'h0,        0, 0, 0, 0);
        vecs[2]  = mk(0, 1, 8'h01, 1, 0, 0, 32'h0,        0, 0, 0, 0);
        vecs[3]  = mk(0, 1, 8'h00, 1, 0, 0, 32'h0,        0, 0, 0, 0);
        vecs[4]  = mk(0, 1, 8'h0B, 1, 0, 0, 32'h0,        0, 0, 0, 0);
        vecs[5]  = mk(0, 1, 8'h20, 0, 1, 0, 32'h2001000B, 0, 0, 0, 0);
        vecs[6]  = mk(0, 1, 8'h20, 1, 0, 0, 32'h2001000B, 1, 0, 0, 0);
        vecs[7]  = mk(0, 1, 8'h22, 1, 0, 0, 32'h2001000B, 1, 0, 0, 0);
        vecs[8]  = mk(0, 1, 8'h00, 1, 0, 0, 32'h2001000B, 1, 0, 0, 0);
        vecs[9]  = mk(0, 1, 8'h1E, 1, 0, 0, 32'h2001000B, 1, 0, 0, 0);
        vecs[10] = mk(0, 1, 8'hFC, 0, 1, 1, 32'h2022001E, 1, 0, 0, 0);
        vecs[11] = mk(0, 1, 8'hFC, 1, 0, 1, 32'h2022001E, 2, 0, 0, 0);
        vecs[12] = mk(0, 1, 8'h00, 1, 0, 1, 32'h2022001E, 2, 0, 0, 0);
        vecs[13] = mk(0, 1, 8'h00, 1, 0, 1, 32'h2022001E, 2, 0, 0, 0);
        vecs[14] = mk(0, 1, 8'h00, 1, 0, 1, 32'h2022001E, 2, 0, 0, 0);
        vecs[15] = mk(0, 0, 8'h00, 0, 1, 2, 32'hFC000000, 2, 0, 0, 0);
        vecs[16] = mk(0, 1, 8'hAA, 0, 0, 2, 32'hFC000000, 3, 1, 1, 0);
        vecs[17] = mk(0, 0, 8'h00, 0, 0, 2, 32'hFC000000, 3, 1, 1, 0);

        // Reset, then idle with no start
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("idle_outs[%0d]", i), 64'(outs()), 64'd0);
        end
        chk("idle_no_write", 64'(wr_cnt), 64'd0);

        // Basic load from the cycle table
        for (int i = 0; i < 18; i++) begin
            chk($sformatf("vec[%0d]", i), 64'(outs()), 64'(vecs[i].exp));
            start        = vecs[i].start;
            bif.rx_valid = vecs[i].valid;
            bif.rx_data  = vecs[i].data;
            @(negedge clk);
        end
        start        = 1'b0;
        bif.rx_valid = 1'b0;
        chk("basic_mem0", 64'(mem_model[0]), 64'h2001000B);
        chk("basic_mem1", 64'(mem_model[1]), 64'h2022001E);
        chk("basic_mem2", 64'(mem_model[2]), 64'hFC000000);
        chk("basic_wr_cnt", 64'(wr_cnt), 64'd3);

        // Throttled source: same program, random gaps
        for (int i = 0; i < 3; i++) mem_model[i] = 32'h0;
        wr_cnt = 0;
        pulse_start();
        send_word(32'h2001000B, 5);
        send_word(32'h2022001E, 5);
        send_word(32'hFC000000, 5);
        wait_end("throttle");
        chk("thr_mem0", 64'(mem_model[0]), 64'h2001000B);
        chk("thr_mem1", 64'(mem_model[1]), 64'h2022001E);
        chk("thr_mem2", 64'(mem_model[2]), 64'hFC000000);
        chk("thr_wr_cnt", 64'(wr_cnt), 64'd3);
        chk("thr_done_run_cnt", 64'({load_done, cpu_run, word_count}), 64'({2'b11, 11'd3}));
        chk("thr_single_pulse", 64'(dbl), 64'd0);

        // Overflow: full memory of NOPs, no FINISH
        wr_cnt = 0;
        pulse_start();
        for (int w = 0; w < int'(DEPTH); w++) send_word(32'h0, 0);
        wait_end("overflow");
        chk("ovf_wr_cnt", 64'(wr_cnt), 64'd1024);
        chk("ovf_last_a", 64'(last_a), 64'd1023);
        chk("ovf_err_run_done", 64'({load_err, cpu_run, load_done}), 64'(3'b100));
        chk("ovf_word_count", 64'(word_count), 64'd1024);
        bif.rx_valid = 1'b1;
        bif.rx_data  = 8'h55;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("ovf_no_ready[%0d]", i), 64'(bif.rx_ready), 64'd0);
        end
        bif.rx_valid = 1'b0;
        chk("ovf_no_more_writes", 64'(wr_cnt), 64'd1024);

        // FINISH at the last address, started from ERROR
        wr_cnt = 0;
        pulse_start();
        chk("err_cleared_on_start", 64'({load_err, bif.rx_ready}), 64'(2'b01));
        for (int w = 0; w < int'(DEPTH) - 1; w++) send_word(32'h0, 0);
        send_word(32'hFC000000, 0);
        wait_end("last_finish");
        chk("last_done_err_run", 64'({load_done, load_err, cpu_run}), 64'(3'b101));
        chk("last_word_count", 64'(word_count), 64'd1024);
        chk("last_write", 64'({last_a, last_d}), 64'({10'd1023, 32'hFC000000}));
        chk("last_wr_cnt", 64'(wr_cnt), 64'd1024);

        // Reset mid-word, then a fresh two-word load
        pulse_start();
        send_byte(8'hAB, 0);
        send_byte(8'hCD, 0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_outs", 64'(outs()), 64'd0);
        wr_cnt = 0;
        pulse_start();
        send_word(32'h13579BDF, 2);
        send_word(32'hFC000000, 2);
        wait_end("reload");
        chk("reload_first_write", 64'({first_a, first_d}), 64'({10'd0, 32'h13579BDF}));
        chk("reload_mem1", 64'(mem_model[1]), 64'hFC000000);
        chk("reload_wr_cnt", 64'(wr_cnt), 64'd2);
        chk("reload_done_run", 64'({load_done, cpu_run, word_count}), 64'({2'b11, 11'd2}));

        // Restart from DONE: run/done fall as rx_ready rises, then overwrite address 0
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("restart_handover", 64'({cpu_run, load_done, bif.rx_ready, word_count}),
            64'({3'b001, 11'd0}));
        wr_cnt = 0;
        send_word(32'hFC000000, 0);
        wait_end("rewrite");
        chk("rewrite_first_write", 64'({first_a, first_d}), 64'({10'd0, 32'hFC000000}));
        chk("rewrite_mem0", 64'(mem_model[0]), 64'hFC000000);
        chk("final_single_pulse", 64'(dbl), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
